// File: rtl/ip_lb_dispatch.sv
// ---------------------------------------------------------------------------
// ip_lb_dispatch
//   Per-flow dispatch controller behind the IP load-balancer parser. Flits of
//   each message are held in a first-word-fall-through buffer until that
//   message's 4-tuple arrives. The tuple is hashed to one of NUM_DSTS
//   destinations, and the whole message is then drained, in order, to that
//   destination. A 32-bit count of dispatched messages is kept for debug.
//
// Ports
//   clk, rst                       : clock, async active-high reset
//   src_ip_lb_dispatch_val/data/last, ip_lb_dispatch_src_rdy
//                                  : flit input stream from the parser
//   src_ip_lb_dispatch_tuple_val/tuple, ip_lb_dispatch_src_tuple_rdy
//                                  : 4-tuple side channel
//   ip_lb_dispatch_dst_val[NUM_DSTS] : one-hot valid per destination
//   ip_lb_dispatch_dst_data/last   : shared output bus
//   dst_ip_lb_dispatch_rdy[NUM_DSTS] : per-destination ready
//   ip_lb_dispatch_msg_cnt         : messages dispatched (wraps)
// ---------------------------------------------------------------------------
package ip_lb_dispatch_pkg;
  typedef struct packed {
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
  } hash_struct;
endpackage

module ip_lb_dispatch
  import ip_lb_dispatch_pkg::*;
#(
  parameter int NUM_DSTS       = 4,
  parameter int BUF_DEPTH_LOG2 = 4,
  parameter int NOC_DATA_WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      src_ip_lb_dispatch_val,
  input  logic [NOC_DATA_WIDTH-1:0] src_ip_lb_dispatch_data,
  input  logic                      src_ip_lb_dispatch_last,
  output logic                      ip_lb_dispatch_src_rdy,
  input  logic                      src_ip_lb_dispatch_tuple_val,
  input  hash_struct                src_ip_lb_dispatch_tuple,
  output logic                      ip_lb_dispatch_src_tuple_rdy,
  output logic [NUM_DSTS-1:0]       ip_lb_dispatch_dst_val,
  output logic [NOC_DATA_WIDTH-1:0] ip_lb_dispatch_dst_data,
  output logic                      ip_lb_dispatch_dst_last,
  input  logic [NUM_DSTS-1:0]       dst_ip_lb_dispatch_rdy,
  output logic [31:0]               ip_lb_dispatch_msg_cnt
);

  localparam int IDX_W = $clog2(NUM_DSTS);
  localparam int DEPTH = 1 << BUF_DEPTH_LOG2;
  localparam int PTR_W = BUF_DEPTH_LOG2 + 1;

  typedef enum logic {WAIT_TUPLE = 1'b0, DRAIN = 1'b1} state_e;

  typedef struct packed {
    logic [NOC_DATA_WIDTH-1:0] data;
    logic                      last;
  } flit_t;

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [IDX_W-1:0]  sel_q, sel_d;
  logic [31:0]       msg_cnt_q, msg_cnt_d;

  flit_t             buf_mem [DEPTH];
  flit_t             head;
  logic              full, empty, push, pop;
  logic [31:0]       h32;
  logic [15:0]       fold;
  logic [IDX_W-1:0]  hash_idx;

  // ---------------------------------------------------------------------------
  // Flit buffer. Pointers carry one extra wrap bit so full and empty are
  // distinguishable without a separate occupancy counter.
  // ---------------------------------------------------------------------------
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                 (wr_ptr_q[PTR_W-2:0] == rd_ptr_q[PTR_W-2:0]);

  // Ready depends only on full, so a push/pop pair can never hit a full buffer.
  assign ip_lb_dispatch_src_rdy = ~rst & ~full;
  assign push = src_ip_lb_dispatch_val & ip_lb_dispatch_src_rdy;
  assign head = buf_mem[rd_ptr_q[PTR_W-2:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      buf_mem[wr_ptr_q[PTR_W-2:0]] <= '{data: src_ip_lb_dispatch_data,
                                        last: src_ip_lb_dispatch_last};
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, pop};
  end

  // ---------------------------------------------------------------------------
  // Tuple hash: xor everything down to 32 bits, fold to 16, keep the low bits.
  // ---------------------------------------------------------------------------
  assign h32 = src_ip_lb_dispatch_tuple.src_ip ^ src_ip_lb_dispatch_tuple.dst_ip ^
               {src_ip_lb_dispatch_tuple.src_port, src_ip_lb_dispatch_tuple.dst_port};
  assign fold     = h32[31:16] ^ h32[15:0];
  assign hash_idx = fold[IDX_W-1:0];

  // ---------------------------------------------------------------------------
  // Dispatch FSM. dst_val is a function of state and buffer occupancy only;
  // dst_rdy affects nothing but the pop.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d                      = state_q;
    sel_d                        = sel_q;
    msg_cnt_d                    = msg_cnt_q;
    pop                          = 1'b0;
    ip_lb_dispatch_src_tuple_rdy = 1'b0;
    ip_lb_dispatch_dst_val       = '0;
    case (state_q)
      WAIT_TUPLE: begin
        ip_lb_dispatch_src_tuple_rdy = ~rst;
        if (src_ip_lb_dispatch_tuple_val && !rst) begin
          sel_d   = hash_idx;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        ip_lb_dispatch_dst_val[sel_q] = ~empty;
        pop = ~empty & dst_ip_lb_dispatch_rdy[sel_q];
        if (pop && head.last) begin
          msg_cnt_d = msg_cnt_q + 32'd1;
          state_d   = WAIT_TUPLE;
        end
      end
      default: state_d = WAIT_TUPLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= WAIT_TUPLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      sel_q     <= '0;
      msg_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      sel_q     <= sel_d;
      msg_cnt_q <= msg_cnt_d;
    end
  end

  assign ip_lb_dispatch_dst_data = head.data;
  assign ip_lb_dispatch_dst_last = head.last;
  assign ip_lb_dispatch_msg_cnt  = msg_cnt_q;

endmodule

// File: tb/tb_ip_lb_dispatch.sv
// ---------------------------------------------------------------------------
// tb_ip_lb_dispatch
//   Directed bench for ip_lb_dispatch (4 destinations, 16-deep buffer).
//   A negedge monitor matches every output handshake against a queue of
//   hand-computed {destination, data, last} entries.
// ---------------------------------------------------------------------------
module tb_ip_lb_dispatch;
  import ip_lb_dispatch_pkg::*;

  localparam int DW = 32;

  logic          clk, rst;
  logic          src_val, src_last, src_rdy;
  logic [DW-1:0] src_data;
  logic          tup_val, tup_rdy;
  hash_struct    tup;
  logic [3:0]    dst_val, dst_rdy, rdy_drv;
  logic [DW-1:0] dst_data;
  logic          dst_last;
  logic [31:0]   msg_cnt;
  logic          bp_en, bp_phase;

  ip_lb_dispatch #(.NUM_DSTS(4), .BUF_DEPTH_LOG2(4), .NOC_DATA_WIDTH(DW)) dut (
    .clk                          (clk),
    .rst                          (rst),
    .src_ip_lb_dispatch_val       (src_val),
    .src_ip_lb_dispatch_data      (src_data),
    .src_ip_lb_dispatch_last      (src_last),
    .ip_lb_dispatch_src_rdy       (src_rdy),
    .src_ip_lb_dispatch_tuple_val (tup_val),
    .src_ip_lb_dispatch_tuple     (tup),
    .ip_lb_dispatch_src_tuple_rdy (tup_rdy),
    .ip_lb_dispatch_dst_val       (dst_val),
    .ip_lb_dispatch_dst_data      (dst_data),
    .ip_lb_dispatch_dst_last      (dst_last),
    .dst_ip_lb_dispatch_rdy       (dst_rdy),
    .ip_lb_dispatch_msg_cnt       (msg_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dst_rdy[3] toggles every cycle while bp_en is set
  initial bp_phase = 1'b1;
  always @(posedge clk) #1 bp_phase = ~bp_phase;
  assign dst_rdy = bp_en ? {bp_phase, rdy_drv[2:0]} : rdy_drv;

  int n_chk = 0, n_err = 0;
  int cyc = 0, n_pop = 0, last_pop_cyc = 0, tup_acc_cyc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [1:0]    sel;
    logic [DW-1:0] data;
    logic          last;
  } exp_t;
  exp_t exp_q[$];

  logic        held_v = 1'b0;
  logic [32:0] held;

  always @(posedge clk) cyc++;

  // Output monitor
  always @(negedge clk) begin
    logic [3:0] onehot;
    if (exp_q.size() != 0) onehot = 4'b0001 << exp_q[0].sel;
    else                   onehot = 4'b0000;
    if (dst_val != 4'b0000) begin
      if (exp_q.size() == 0) begin
        chk("spurious_val", {60'b0, dst_val}, 64'd0);
      end else begin
        chk("dst_onehot", {60'b0, dst_val}, {60'b0, onehot});
        if (held_v) chk("held_stable", {31'b0, dst_data, dst_last}, {31'b0, held});
        if ((dst_val & dst_rdy) != 4'b0000) begin
          chk("data", {32'b0, dst_data}, {32'b0, exp_q[0].data});
          chk("last", {63'b0, dst_last}, {63'b0, exp_q[0].last});
          if (dst_last) last_pop_cyc = cyc;
          n_pop++;
          void'(exp_q.pop_front());
          held_v = 1'b0;
        end else begin
          held_v = 1'b1;
          held   = {dst_data, dst_last};
        end
      end
    end else if (held_v && !rst) begin
      chk("val_held", {60'b0, dst_val}, {60'b0, onehot});
    end
  end

  task automatic push_flit(input logic [1:0] sel, input logic [DW-1:0] d, input logic l);
    exp_t e;
    int   t = 0;
    e.sel = sel; e.data = d; e.last = l;
    exp_q.push_back(e);
    src_val = 1'b1; src_data = d; src_last = l;
    @(negedge clk);
    while (!src_rdy && t < 500) begin @(negedge clk); t++; end
    if (!src_rdy) chk("push_timeout", {63'b0, src_rdy}, 64'd1);
    @(posedge clk); #1;
    src_val = 1'b0;
  endtask

  task automatic send_tuple(input hash_struct t_in);
    int t = 0;
    tup_val = 1'b1; tup = t_in;
    @(negedge clk);
    while (!tup_rdy && t < 500) begin @(negedge clk); t++; end
    if (!tup_rdy) chk("tuple_timeout", {63'b0, tup_rdy}, 64'd1);
    tup_acc_cyc = cyc;
    @(posedge clk); #1;
    tup_val = 1'b0;
  endtask

  task automatic send_msg(input hash_struct t_in, input logic [1:0] sel, input int n,
                          input logic [DW-1:0] base);
    push_flit(sel, base, n == 1);
    send_tuple(t_in);
    for (int i = 1; i < n; i++) push_flit(sel, base + DW'(i), i == n - 1);
  endtask

  task automatic wait_drain(input string tag);
    int t = 0;
    while (exp_q.size() != 0 && t < 3000) begin @(posedge clk); t++; end
    chk(tag, 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  // Hand-computed: A -> h32 0x1234567B, fold 0x444F, idx 3; B -> fold 0x0001, idx 1
  localparam hash_struct TA = '{src_ip: 32'h0A000001, dst_ip: 32'h0A000002,
                                src_port: 16'h1234, dst_port: 16'h5678};
  localparam hash_struct TB = '{src_ip: 32'h0A000001, dst_ip: 32'h0A000001,
                                src_port: 16'h0000, dst_port: 16'h0001};

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_chk, n_err);
    $fatal(1);
  end

  initial begin
    int p0;
    rst = 1'b0; src_val = 1'b0; src_data = '0; src_last = 1'b0;
    tup_val = 1'b0; tup = '0; rdy_drv = 4'hF; bp_en = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dst_val",   {60'b0, dst_val}, 64'd0);
    chk("rst_src_rdy",   {63'b0, src_rdy}, 64'd0);
    chk("rst_tuple_rdy", {63'b0, tup_rdy}, 64'd0);
    chk("rst_msg_cnt",   {32'b0, msg_cnt}, 64'd0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_src_rdy",   {63'b0, src_rdy}, 64'd1);
    chk("idle_tuple_rdy", {63'b0, tup_rdy}, 64'd1);

    // 1: single 4-flit message to destination 3
    push_flit(2'd3, 32'hA000_0000, 1'b0);
    send_tuple(TA);
    @(negedge clk);
    chk("tuple_latency", {60'b0, dst_val}, 64'h8);
    chk("drain_tuple_rdy", {63'b0, tup_rdy}, 64'd0);
    @(posedge clk); #1;
    for (int i = 1; i < 4; i++) push_flit(2'd3, 32'hA000_0000 + 32'(i), i == 3);
    wait_drain("t1_drain");
    chk("t1_msg_cnt", {32'b0, msg_cnt}, 64'd1);

    // 2: back-to-back A (idx 3) then B (idx 1); B's tuple waits for A's last pop
    rdy_drv = 4'b0111;
    send_msg(TA, 2'd3, 4, 32'hB000_0000);
    push_flit(2'd1, 32'hB100_0000, 1'b0);
    fork
      send_tuple(TB);
      begin repeat (3) @(posedge clk); #1 rdy_drv = 4'hF; end
    join
    chk("b2b_tuple_cycle", 64'(tup_acc_cyc), 64'(last_pop_cyc + 1));
    for (int i = 1; i < 3; i++) push_flit(2'd1, 32'hB100_0000 + 32'(i), i == 2);
    wait_drain("t2_drain");
    chk("t2_msg_cnt", {32'b0, msg_cnt}, 64'd3);

    // 3: backpressure on destination 3, others ready but unselected
    rdy_drv = 4'b0111; bp_en = 1'b1;
    p0 = n_pop;
    send_msg(TA, 2'd3, 6, 32'hC000_0000);
    wait_drain("t3_drain");
    bp_en = 1'b0; rdy_drv = 4'hF;
    chk("t3_pops", 64'(n_pop - p0), 64'd6);
    chk("t3_msg_cnt", {32'b0, msg_cnt}, 64'd4);

    // 4: 40-flit message through a 16-deep buffer
    rdy_drv = 4'b0111;
    p0 = n_pop;
    push_flit(2'd3, 32'hD000_0000, 1'b0);
    send_tuple(TA);
    for (int i = 1; i < 15; i++) push_flit(2'd3, 32'hD000_0000 + 32'(i), 1'b0);
    @(negedge clk);
    chk("fill15_src_rdy", {63'b0, src_rdy}, 64'd1);
    @(posedge clk); #1;
    push_flit(2'd3, 32'hD000_000F, 1'b0);
    @(negedge clk);
    chk("fill16_src_rdy", {63'b0, src_rdy}, 64'd0);
    @(posedge clk); #1;
    rdy_drv = 4'hF;
    for (int i = 16; i < 40; i++) push_flit(2'd3, 32'hD000_0000 + 32'(i), i == 39);
    wait_drain("t4_drain");
    chk("t4_pops", 64'(n_pop - p0), 64'd40);
    chk("t4_msg_cnt", {32'b0, msg_cnt}, 64'd5);

    // 5: reset after 2 of 6 flits are out
    rdy_drv = 4'b0111;
    p0 = n_pop;
    send_msg(TA, 2'd3, 6, 32'hE000_0000);
    @(posedge clk); #1 rdy_drv = 4'hF;
    @(posedge clk);
    @(posedge clk); #1 rdy_drv = 4'b0111;
    chk("t5_pre_rst_pops", 64'(n_pop - p0), 64'd2);
    #1;
    rst = 1'b1;
    exp_q.delete();
    held_v = 1'b0;
    #1;
    chk("t5_rst_dst_val",   {60'b0, dst_val}, 64'd0);
    chk("t5_rst_src_rdy",   {63'b0, src_rdy}, 64'd0);
    chk("t5_rst_tuple_rdy", {63'b0, tup_rdy}, 64'd0);
    chk("t5_rst_msg_cnt",   {32'b0, msg_cnt}, 64'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    chk("t5_post_src_rdy", {63'b0, src_rdy}, 64'd1);
    chk("t5_post_dst_val", {60'b0, dst_val}, 64'd0);
    rdy_drv = 4'hF;
    send_msg(TB, 2'd1, 3, 32'hF000_0000);
    wait_drain("t5_drain");
    chk("t5_msg_cnt", {32'b0, msg_cnt}, 64'd1);

    // 6: counter wrap
    force dut.msg_cnt_q = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.msg_cnt_q;
    @(posedge clk); #1;
    chk("t6_preload", {32'b0, msg_cnt}, 64'hFFFF_FFFF);
    send_msg(TA, 2'd3, 2, 32'h1234_0000);
    wait_drain("t6_drain");
    chk("t6_wrap", {32'b0, msg_cnt}, 64'd0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
